// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipe (IF ID EX MEM WB).
// Optional perf counters: define HAZARD_PERF_CNT_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs1/id_rs2       source indices of the ID instruction
//   id_use_rs1/2        ID instruction reads that source
//   ex_opcode/ex_wd     opcode and destination of the EX instruction
//   ex_wreg             EX instruction writes a register
//   ex_branch_taken     EX resolved a taken branch/jump, target in
//   ex_branch_target    redirect address
//   mem_req/mem_done    multi-cycle data access start (level) / completion
//   stall[4:0]          hold: pc, if_id, id_ex, ex_mem, mem_wb
//   flush_if_id/id_ex   bubble the matching pipe register next edge
//   pc_redirect         PC loads pc_target next edge
//   mem_timeout_err     sticky memory timeout flag
//   perf_*              (HAZARD_PERF_CNT_EN only) 32-bit event counters
module pipe_hazard_ctrl #(
    parameter int         MEM_TIMEOUT = 255,
    parameter logic [6:0] LOAD_OPCODE = 7'b0000011,
    parameter int         PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [6:0]      ex_opcode,
    input  logic [4:0]      ex_wd,
    input  logic            ex_wreg,
    input  logic            ex_branch_taken,
    input  logic [PC_W-1:0] ex_branch_target,
    input  logic            mem_req,
    input  logic            mem_done,
    output logic [4:0]      stall,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target,
    output logic            mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Last counter value before the wait is abandoned: the counter starts
    // at 0 on the first wait cycle, so this is the MEM_TIMEOUT-th cycle.
    localparam logic [9:0] TIMEOUT_LAST = 10'(MEM_TIMEOUT - 1);

    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] STALL_LU  = 5'b00011;

    state_t          state, state_nxt;
    logic [9:0]      wait_cnt, wait_cnt_nxt;
    logic            pend_vld, pend_vld_nxt;
    logic [PC_W-1:0] pend_tgt, pend_tgt_nxt;
    logic            err_q, err_nxt;
    logic            load_use;

    assign load_use = (ex_opcode == LOAD_OPCODE) && ex_wreg &&
                      (ex_wd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_wd)) ||
                       (id_use_rs2 && (id_rs2 == ex_wd)));

    assign mem_timeout_err = err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            pend_vld <= pend_vld_nxt;
            pend_tgt <= pend_tgt_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        err_nxt      = err_q;
        stall        = '0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_req && !mem_done) begin
                        stall        = STALL_MEM;
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = '0;
                        pend_vld_nxt = ex_branch_taken;
                        if (ex_branch_taken)
                            pend_tgt_nxt = ex_branch_target;
                    end else if (ex_branch_taken) begin
                        // squashes the ID instruction, so no load-use stall
                        pc_redirect = 1'b1;
                        pc_target   = ex_branch_target;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (load_use) begin
                        stall       = STALL_LU;
                        flush_id_ex = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    wait_cnt_nxt = wait_cnt + 10'd1;
                    // first branch seen while frozen is the one honoured
                    if (ex_branch_taken && !pend_vld) begin
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = ex_branch_target;
                    end
                    if (mem_done) begin
                        state_nxt = (pend_vld || ex_branch_taken) ?
                                    REDIRECT : RUN;
                    end else begin
                        stall = STALL_MEM;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            err_nxt      = 1'b1;
                            state_nxt    = RUN;
                            pend_vld_nxt = 1'b0;
                        end
                    end
                end

                REDIRECT: begin
                    pc_redirect  = 1'b1;
                    pc_target    = pend_tgt;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = RUN;
                end

                default: begin
                    state_nxt    = RUN;
                    pend_vld_nxt = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // flush_id_ex without a redirect only comes from a load-use bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_bubbles      <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall[0])
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_id_ex && !pc_redirect)
                perf_bubbles <= perf_bubbles + 32'd1;
            if (pc_redirect)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Drives the hold and bubble controls of every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) from three sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses.
- Contains a small FSM that freezes the pipe during memory waits, latches a branch redirect that arrives while frozen, and enforces a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before mem_timeout_err asserts; range 1..1023.
- LOAD_OPCODE, 7'b0000011: EX opcode that identifies a load.
- PC_W, 32: width of the redirect target.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_opcode  in  7  opcode currently in EX
- ex_wd  in  5  EX destination register
- ex_wreg  in  1  EX writes a register
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_branch_target  in  PC_W  redirect address
- mem_req  in  1  MEM stage starts a multi-cycle access (level, held until done)
- mem_done  in  1  memory access completes this cycle
- stall  out  5  hold enables: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
- flush_if_id  out  1  load NOP into if_id next edge
- flush_id_ex  out  1  load NOP (all-zero fields, wreg=0) into id_ex next edge
- pc_redirect  out  1  PC loads pc_target next edge
- pc_target  out  PC_W  redirect address
- mem_timeout_err  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, REDIRECT.
- Reset: state=RUN, wait counter=0, pending-branch register clear, pending target=0, mem_timeout_err=0. While rst is high all outputs are 0, pc_target=0. Reset mid-MEM_WAIT abandons the wait and discards any pending branch.
- Outputs are combinational from state, registers and inputs (zero-latency control). State and counters update on the clk edge.
- Load-use hazard: ex_opcode==LOAD_OPCODE && ex_wreg && ex_wd!=0 && ((id_use_rs1 && id_rs1==ex_wd) || (id_use_rs2 && id_rs2==ex_wd)).
- RUN, priority high to low:
  - mem_req && !mem_done: stall=5'b01111, flush outputs 0. A same-cycle ex_branch_taken is captured into the pending register (target latched). Go to MEM_WAIT and clear the counter.
  - ex_branch_taken: pc_redirect=1, pc_target=ex_branch_target, flush_if_id=1, flush_id_ex=1, stall=0. Overrides any load-use hazard, because the ID instruction is being squashed. Stay in RUN.
  - Load-use hazard: stall=5'b00011, flush_id_ex=1, giving exactly one bubble.
  - Otherwise all outputs 0.
  - mem_req together with mem_done in the same cycle counts as a single-cycle access: no stall.
- MEM_WAIT:
  - stall=5'b01111, the mem_wb bubble comes from the MEM stage, and the counter increments.
  - A taken branch seen here is latched if none is pending; the first one wins.
  - On mem_done, stall is released that cycle. Go to REDIRECT if a branch is pending, otherwise RUN.
  - When the counter reaches MEM_TIMEOUT: set mem_timeout_err (sticky until rst), force a return to RUN, and drop the pending branch.
- REDIRECT (one cycle): pc_redirect=1, pc_target=pending target, flush_if_id=1, flush_id_ex=1. Clear the pending register and return to RUN.
- Load-use detection is suppressed in MEM_WAIT and REDIRECT.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_stall_cycles, perf_bubbles and perf_flushes.
  - perf_stall_cycles increments on any cycle with stall[0]=1.
  - perf_bubbles increments on load-use bubbles.
  - perf_flushes increments on pc_redirect cycles.
  - All three reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: EX opcode=0000011, ex_wd=5, ex_wreg=1; ID id_rs2=5, id_use_rs2=1 -> one cycle of stall=00011 and flush_id_ex=1, then 0. Same case with ex_wd=0 -> no stall.
- Taken branch together with load-use hazard, target 32'h0000_0040 -> pc_redirect=1, pc_target=0x40, both flushes=1, stall=0.
- mem_req for 3 cycles with mem_done on cycle 3 -> stall=01111 on cycles 1-2, 0 on cycle 3. A branch (target 0x80) in cycle 2 -> REDIRECT cycle with pc_target=0x80 immediately after.
- MEM_TIMEOUT=4, mem_req held with no mem_done -> mem_timeout_err=1 after 4 wait cycles, FSM back in RUN, flag stays high until rst.
- rst asserted mid-MEM_WAIT with a pending branch -> next cycle all outputs 0, no redirect after release.
- With HAZARD_PERF_CNT_EN: 1 bubble + 1 redirect + 2-cycle mem wait -> perf_bubbles=1, perf_flushes=1, perf_stall_cycles=3.
